// File: rtl/dlx_ctrl_pipe.sv
// dlx_ctrl_pipe: registered ID->EX control stage for the DLX pipeline with load-use stalls.
// Define DLX_MUL_EN to add the MULT instruction and its multi-cycle multiply sequencer.
module dlx_ctrl_pipe #(
  parameter int ALU_W   = 4,
  parameter int RA_W    = 5,
  parameter int MUL_LAT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       InstrD,
  input  logic              ValidD,
  input  logic              StallE,
  input  logic              FlushE,
  output logic              StallD,
  output logic              ValidE,
  output logic              RegWriteE,
  output logic              MemtoRegE,
  output logic              MemWriteE,
  output logic              ALUSrcE,
  output logic              ALUSrcNoExE,
  output logic              RegDstE,
  output logic              BranchEE,
  output logic              BranchNEE,
  output logic              Branch2RegE,
  output logic              Branch2ValueE,
  output logic              LinkE,
  output logic              IllegalE,
  output logic [ALU_W-1:0]  ALUControlE,
  output logic [RA_W-1:0]   RsE,
  output logic [RA_W-1:0]   RtE,
  output logic [RA_W-1:0]   WrAddrE,
  output logic              MulBusy
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQZ  = 6'h04;
  localparam logic [5:0] OP_BNEZ  = 6'h05;
  localparam logic [5:0] OP_ANDI  = 6'h0c;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_XORI  = 6'h0e;
  localparam logic [5:0] OP_JR    = 6'h12;
  localparam logic [5:0] OP_JALR  = 6'h13;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  typedef struct packed {
    logic             valid;
    logic             reg_write;
    logic             mem_to_reg;
    logic             mem_write;
    logic             alu_src;
    logic             alu_src_no_ex;
    logic             reg_dst;
    logic             branch_eq;
    logic             branch_ne;
    logic             branch_reg;
    logic             branch_value;
    logic             link;
    logic             illegal;
    logic [ALU_W-1:0] alu;
    logic [RA_W-1:0]  rs;
    logic [RA_W-1:0]  rt;
    logic [RA_W-1:0]  wr;
  } ctrl_t;

  logic [5:0]      op;
  logic [5:0]      funct;
  logic [RA_W-1:0] rs_d;
  logic [RA_W-1:0] rt_d;
  logic [RA_W-1:0] rd_d;
  logic [3:0]      r_code;
  logic [3:0]      i_code;
  logic            dec_illegal;
  logic            reads_rt;
  logic            hazard;
  logic            mul_busy;
  logic            load_normal;
  logic            unused_shamt;
  ctrl_t           dec;
  ctrl_t           load_bundle;
  ctrl_t           e_q;

  assign op           = InstrD[31:26];
  assign funct        = InstrD[5:0];
  assign rs_d         = RA_W'(InstrD[25:21]);
  assign rt_d         = RA_W'(InstrD[20:16]);
  assign rd_d         = RA_W'(InstrD[15:11]);
  assign unused_shamt = ^InstrD[10:6];

  // R-type ALU code by funct; zero marks an unlisted funct.
  always_comb begin
    r_code = 4'h0;
    case (funct)
      6'h20: r_code = 4'h1;
      6'h24: r_code = 4'h2;
      6'h25: r_code = 4'h3;
      6'h22: r_code = 4'h4;
      6'h26: r_code = 4'h5;
      6'h04: r_code = 4'h6;
      6'h28: r_code = 4'h7;
      6'h29: r_code = 4'h8;
      6'h06: r_code = 4'h9;
      6'h2c: r_code = 4'ha;
      6'h2a: r_code = 4'hb;
      6'h07: r_code = 4'hc;
`ifdef DLX_MUL_EN
      6'h0e: r_code = 4'he;
`endif
      default: r_code = 4'h0;
    endcase
  end

  // I-type ALU code by opcode; zero marks an opcode that is not an immediate ALU op.
  always_comb begin
    i_code = 4'h0;
    case (op)
      6'h08: i_code = 4'h1;
      6'h0c: i_code = 4'h2;
      6'h0d: i_code = 4'h3;
      6'h0a: i_code = 4'h4;
      6'h0e: i_code = 4'h5;
      6'h14: i_code = 4'h6;
      6'h18: i_code = 4'h7;
      6'h19: i_code = 4'h8;
      6'h16: i_code = 4'h9;
      6'h1c: i_code = 4'ha;
      6'h1a: i_code = 4'hb;
      6'h17: i_code = 4'hc;
      6'h0f: i_code = 4'hd;
      default: i_code = 4'h0;
    endcase
  end

  always_comb begin
    dec         = '0;
    dec.valid   = 1'b1;
    dec.rs      = rs_d;
    dec.rt      = rt_d;
    dec_illegal = 1'b0;
    case (op)
      OP_RTYPE: begin
        dec.reg_dst   = 1'b1;
        dec.reg_write = 1'b1;
        dec.alu       = ALU_W'(r_code);
        dec_illegal   = (r_code == 4'h0);
      end
      OP_LW: begin
        dec.reg_write  = 1'b1;
        dec.mem_to_reg = 1'b1;
        dec.alu_src    = 1'b1;
        dec.alu        = ALU_W'(4'h1);
      end
      OP_SW: begin
        dec.mem_write = 1'b1;
        dec.alu_src   = 1'b1;
        dec.alu       = ALU_W'(4'h1);
      end
      OP_BEQZ: begin
        dec.branch_eq = 1'b1;
        dec.alu_src   = 1'b1;
      end
      OP_BNEZ: begin
        dec.branch_ne = 1'b1;
        dec.alu_src   = 1'b1;
      end
      OP_J:    dec.branch_value = 1'b1;
      OP_JR:   dec.branch_reg   = 1'b1;
      OP_JAL: begin
        dec.branch_value = 1'b1;
        dec.link         = 1'b1;
        dec.reg_write    = 1'b1;
      end
      OP_JALR: begin
        dec.branch_reg = 1'b1;
        dec.link       = 1'b1;
        dec.reg_write  = 1'b1;
      end
      default: begin
        dec.reg_write     = 1'b1;
        dec.alu_src       = 1'b1;
        dec.alu_src_no_ex = (op == OP_ANDI) || (op == OP_ORI) || (op == OP_XORI);
        dec.alu           = ALU_W'(i_code);
        dec_illegal       = (i_code == 4'h0);
      end
    endcase
    // Links always target r31; otherwise R-type writes Rd and everything else Rt.
    if (dec.link) begin
      dec.wr = RA_W'(31);
    end else if (dec.reg_dst) begin
      dec.wr = rd_d;
    end else begin
      dec.wr = rt_d;
    end
  end

  // An illegal word carries only its valid/illegal marker into EX so nothing downstream acts on it.
  always_comb begin
    load_bundle = '0;
    if (ValidD) begin
      if (dec_illegal) begin
        load_bundle.valid   = 1'b1;
        load_bundle.illegal = 1'b1;
      end else begin
        load_bundle = dec;
      end
    end
  end

  assign reads_rt = (op == OP_RTYPE) || (op == OP_SW) || (op == OP_BEQZ) || (op == OP_BNEZ);

  assign hazard = ValidD && e_q.valid && e_q.mem_to_reg && (e_q.wr != '0) &&
                  ((e_q.wr == rs_d) || ((e_q.wr == rt_d) && reads_rt));

  assign load_normal = !FlushE && !StallE && !hazard && !mul_busy;
  assign StallD      = rst_n && (StallE || hazard || mul_busy);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_q <= '0;
    end else if (FlushE) begin
      e_q <= '0;
    end else if (StallE) begin
      e_q <= e_q;
    end else if (hazard || mul_busy) begin
      e_q <= '0;
    end else begin
      e_q <= load_bundle;
    end
  end

`ifdef DLX_MUL_EN
  localparam int CNT_W = $clog2(MUL_LAT + 1);

  typedef enum logic {IDLE, BUSY} mul_state_t;

  mul_state_t       state;
  logic [CNT_W-1:0] count;
  logic             is_mult;

  assign is_mult = ValidD && (op == OP_RTYPE) && (funct == 6'h0e);

  // BUSY lasts MUL_LAT-1 cycles after MULT enters EX; the last decrement returns to IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      count <= '0;
    end else if (FlushE) begin
      state <= IDLE;
      count <= '0;
    end else if (!StallE) begin
      case (state)
        IDLE: begin
          if (load_normal && is_mult) begin
            state <= BUSY;
            count <= CNT_W'(MUL_LAT - 1);
          end
        end
        BUSY: begin
          if (count <= CNT_W'(1)) begin
            state <= IDLE;
            count <= '0;
          end else begin
            count <= count - CNT_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          count <= '0;
        end
      endcase
    end
  end

  assign mul_busy = (state == BUSY);
`else
  assign mul_busy = 1'b0;
`endif

  assign MulBusy       = mul_busy;
  assign ValidE        = e_q.valid;
  assign RegWriteE     = e_q.reg_write;
  assign MemtoRegE     = e_q.mem_to_reg;
  assign MemWriteE     = e_q.mem_write;
  assign ALUSrcE       = e_q.alu_src;
  assign ALUSrcNoExE   = e_q.alu_src_no_ex;
  assign RegDstE       = e_q.reg_dst;
  assign BranchEE      = e_q.branch_eq;
  assign BranchNEE     = e_q.branch_ne;
  assign Branch2RegE   = e_q.branch_reg;
  assign Branch2ValueE = e_q.branch_value;
  assign LinkE         = e_q.link;
  assign IllegalE      = e_q.illegal;
  assign ALUControlE   = e_q.alu;
  assign RsE           = e_q.rs;
  assign RtE           = e_q.rt;
  assign WrAddrE       = e_q.wr;

endmodule
